load_store_sequencer: RTL and testbench
=======================================

// Module: load_store_sequencer
// PURPOSE
//  Initiator side of the byte-addressable data memory port: accepts load/store requests from the
//  CPU pipeline over a valid/ready handshake and drives memory address/data_in/read_write/width/
//  signed_read. Aligned accesses take one memory cycle; misaligned H/W accesses are split into
//  byte accesses and reassembled. Out-of-range or illegal-width requests return an error.
// PARAMETERS
//  BASE_ADDRESS  32'h0100_0000  first valid byte address of the memory
//  DEPTH         10**6          number of bytes in the memory; valid range [BASE_ADDRESS, BASE_ADDRESS+DEPTH)
// PORTS
//  clock        in   1   single clock, all state updates on posedge
//  reset_n      in   1   synchronous, active-low reset
//  req_valid    in   1   request present; held with all req_* stable until accepted
//  req_ready    out  1   high only in IDLE; accept = req_valid & req_ready at posedge
//  req_write    in   1   1 = store, 0 = load
//  req_width    in   2   2'b01 byte, 2'b10 half, 2'b11 word, 2'b00 illegal
//  req_signed   in   1   sign-extend load result (ignored for stores and W)
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, low bytes used for B/H
//  rsp_valid    out  1   one-cycle pulse: request completed; no back-pressure
//  rsp_rdata    out  32  load result (0 for stores and errors); valid while rsp_valid
//  rsp_error    out  1   request rejected, no memory access made; valid while rsp_valid
//  mem_address  out  32  to memory address
//  mem_data_in  out  32  to memory data_in
//  mem_data_out in   32  from memory data_out (combinational read)
//  mem_rw       out  1   to memory read_write: 1 = read, 0 = write at next posedge
//  mem_width    out  2   to memory width
//  mem_signed   out  1   to memory signed_read
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0,
//    byte counter=0, assembly buffer=0. Memory port goes to idle drive.
//  - Idle drive (any cycle not in ACCESS/SPLIT): mem_rw=1, mem_width=2'b11, mem_address=BASE_ADDRESS,
//    mem_data_in=0, mem_signed=0. mem_rw is never 0 outside an access cycle.
//  - On accept, request is registered; bytes n = 1/2/4. error = width==2'b00 or addr<BASE_ADDRESS or
//    addr+n > BASE_ADDRESS+DEPTH (33-bit compare, no wrap). misaligned = (H & addr[0]) | (W & addr[1:0]!=0).
//  - States: IDLE -> ERR (error) | ACCESS (aligned) | SPLIT (misaligned); ERR/ACCESS/last SPLIT -> IDLE.
//  - ERR: one cycle, idle drive; at its closing posedge rsp_valid=1, rsp_error=1, rsp_rdata=0.
//  - ACCESS: one cycle driving registered addr/width/wdata, mem_rw=~req_write, mem_signed=req_signed.
//    Closing posedge: store commits in memory; load captures mem_data_out into rsp_rdata; rsp_valid=1.
//    Latency: accept edge k -> rsp_valid high in the cycle after edge k+1.
//  - SPLIT: n cycles, counter i=0..n-1: mem_address=addr+i, mem_width=2'b01, mem_signed=0,
//    mem_data_in[7:0]=wdata byte i, upper bits 0. Load: byte i captured into buffer[8i+7:8i] each edge.
//    Closing posedge of i=n-1: rsp_valid=1; rsp_rdata = buffer, sign-extended from bit 15 if H & req_signed,
//    else zero-extended. Latency: accept edge k -> rsp_valid after edge k+n.
//  - rsp_valid is a single-cycle pulse; state is IDLE (req_ready=1) in that same cycle, so a new request
//    may be accepted on the edge that ends the pulse. Max throughput: one aligned request per 2 cycles.
//  - Stores: rsp_rdata=0, rsp_error=0. Byte accesses are never split.
//  - Reset mid-operation: bytes driven as writes in the cycle whose posedge samples reset_n=0 are committed
//    by memory; no further split bytes are written, no rsp_valid is produced for the aborted request.
// TESTING
//  1. Aligned SW 0xDEADBEEF @0x0100_0010, then LW @0x0100_0010 -> rsp_rdata=0xDEADBEEF, each rsp 2 cycles after accept.
//  2. Misaligned SW 0x11223344 @0x0100_0005 -> 4 byte writes to 0x..05..08, mem_rw=0 exactly 4 cycles;
//     LW @0x0100_0005 -> 0x11223344; LBU @0x0100_0008 -> 0x00000011.
//  3. SH 0x80F0 @0x0100_0021 (split, 2 cycles); LH -> 0xFFFF80F0, LHU -> 0x000080F0, LB @0x0100_0022 -> 0xFFFFFF80.
//  4. LW @0x00FF_FFFE and SW @BASE+DEPTH-2, req_width=2'b00 -> rsp_error=1, rsp_rdata=0, mem_rw stays 1 throughout.
//  5. req_valid held during SPLIT -> req_ready=0, request accepted only on edge ending rsp_valid; back-to-back LWs respond every 2 cycles.
//  6. reset_n=0 during cycle i=1 of misaligned SW 0xAABBCCDD @0x0100_0031 -> bytes 0x31,0x32 = DD,CC; 0x33,0x34 unchanged; no rsp_valid; outputs at reset values.

Source files
------------

// File: rtl/load_store_sequencer.sv
// Load/store sequencer: drives a byte-addressable memory port from a valid/ready request stream,
// splitting misaligned half/word accesses into byte accesses and reassembling load data.
module load_store_sequencer #(
   parameter logic [31:0] BASE_ADDRESS = 32'h0100_0000,
   parameter int          DEPTH        = 10**6
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_width,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic        mem_rw,
   output logic [1:0]  mem_width,
   output logic        mem_signed
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ERR,
      S_ACCESS,
      S_SPLIT
   } state_t;

   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDRESS} + 33'(DEPTH);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] buf_q, buf_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_error_q, rsp_error_d;
   logic        write_q, write_d;
   logic [1:0]  width_q, width_d;
   logic        signed_q, signed_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   logic [32:0] req_bytes;
   logic [32:0] req_end;
   logic        req_err;
   logic        req_misaligned;
   logic [1:0]  last_idx;
   logic [7:0]  wbyte [4];
   logic [31:0] buf_ins;
   logic [31:0] split_rdata;

   // Request decode on the live inputs; only used on the accept edge.
   always_comb begin
      case (req_width)
         2'b01:   req_bytes = 33'd1;
         2'b10:   req_bytes = 33'd2;
         2'b11:   req_bytes = 33'd4;
         default: req_bytes = 33'd0;
      endcase
   end

   assign req_end        = {1'b0, req_addr} + req_bytes;
   assign req_err        = (req_width == 2'b00) || (req_addr < BASE_ADDRESS) || (req_end > LIMIT);
   assign req_misaligned = ((req_width == 2'b10) && req_addr[0]) ||
                           ((req_width == 2'b11) && (req_addr[1:0] != 2'b00));

   assign last_idx = (width_q == 2'b10) ? 2'd1 : 2'd3;

   // Byte lanes: store byte selection and load reassembly (current byte merged in-flight).
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign wbyte[gi]             = wdata_q[8*gi +: 8];
         assign buf_ins[8*gi +: 8]    = (cnt_q == 2'(gi)) ? mem_data_out[7:0] : buf_q[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      split_rdata = buf_ins;
      if (width_q == 2'b10) begin
         split_rdata = signed_q ? {{16{buf_ins[15]}}, buf_ins[15:0]} : {16'h0000, buf_ins[15:0]};
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      buf_d       = buf_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 32'h0;
      rsp_error_d = 1'b0;
      write_d     = write_q;
      width_d     = width_q;
      signed_d    = signed_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      req_ready   = 1'b0;
      mem_rw      = 1'b1;
      mem_width   = 2'b11;
      mem_address = BASE_ADDRESS;
      mem_data_in = 32'h0;
      mem_signed  = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               write_d  = req_write;
               width_d  = req_width;
               signed_d = req_signed;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               cnt_d    = 2'd0;
               buf_d    = 32'h0;
               if (req_err) begin
                  state_d = S_ERR;
               end else if (req_misaligned) begin
                  state_d = S_SPLIT;
               end else begin
                  state_d = S_ACCESS;
               end
            end
         end

         S_ERR: begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
         end

         S_ACCESS: begin
            mem_rw      = ~write_q;
            mem_width   = width_q;
            mem_address = addr_q;
            mem_data_in = wdata_q;
            mem_signed  = signed_q;
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = write_q ? 32'h0 : mem_data_out;
         end

         S_SPLIT: begin
            mem_rw      = ~write_q;
            mem_width   = 2'b01;
            mem_address = addr_q + {30'h0, cnt_q};
            mem_data_in = {24'h0, wbyte[cnt_q]};
            if (!write_q) begin
               buf_d = buf_ins;
            end
            if (cnt_q == last_idx) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = write_q ? 32'h0 : split_rdata;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         buf_q       <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_error_q <= 1'b0;
         write_q     <= 1'b0;
         width_q     <= 2'b11;
         signed_q    <= 1'b0;
         addr_q      <= BASE_ADDRESS;
         wdata_q     <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
         write_q     <= write_d;
         width_q     <= width_d;
         signed_q    <= signed_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Bench for load_store_sequencer: byte memory model on the memory port, directed vector table,
// hand-written handshake/reset sequences and randomized requests against a request-level model.
module tb_load_store_sequencer;

   localparam logic [31:0] BASE  = 32'h0100_0000;
   localparam int          DEPTH = 1000000;
   localparam logic [31:0] TOP   = BASE + 32'(DEPTH);

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_width;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;
   logic        mem_rw;
   logic [1:0]  mem_width;
   logic        mem_signed;

   always #5 clock = ~clock;

   load_store_sequencer #(.BASE_ADDRESS(BASE), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_width(req_width), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .mem_rw(mem_rw), .mem_width(mem_width), .mem_signed(mem_signed)
   );

   // Memory device: 1 KiB image indexed by address[9:0]; low window and top-of-range window don't alias.
   logic [7:0] mem_arr [0:1023];
   logic [9:0] ix0, ix1, ix2, ix3;
   assign ix0 = mem_address[9:0];
   assign ix1 = mem_address[9:0] + 10'd1;
   assign ix2 = mem_address[9:0] + 10'd2;
   assign ix3 = mem_address[9:0] + 10'd3;

   function automatic logic [7:0] init_byte(input int i);
      return 8'(i * 37 + 11);
   endfunction

   always_comb begin
      mem_data_out = {mem_arr[ix3], mem_arr[ix2], mem_arr[ix1], mem_arr[ix0]};
      if (mem_width == 2'b01) begin
         mem_data_out = mem_signed ? {{24{mem_arr[ix0][7]}}, mem_arr[ix0]} : {24'h0, mem_arr[ix0]};
      end else if (mem_width == 2'b10) begin
         mem_data_out = mem_signed ? {{16{mem_arr[ix1][7]}}, mem_arr[ix1], mem_arr[ix0]}
                                   : {16'h0, mem_arr[ix1], mem_arr[ix0]};
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem_arr[i] = init_byte(i);
      forever begin
         @(posedge clock);
         if (mem_rw === 1'b0) begin
            mem_arr[ix0] = mem_data_in[7:0];
            if (mem_width[1]) mem_arr[ix1] = mem_data_in[15:8];
            if (mem_width == 2'b11) begin
               mem_arr[ix2] = mem_data_in[23:16];
               mem_arr[ix3] = mem_data_in[31:24];
            end
         end
      end
   end

   // Reference model: request-level semantics over its own byte image.
   logic [7:0] ref_mem [0:1023];

   task automatic ref_req(input logic w, input logic [1:0] wd, input logic sg, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat, output int wrc);
      longint unsigned aa;
      int n;
      bit mis;
      aa  = a;
      n   = (wd == 2'b01) ? 1 : (wd == 2'b10) ? 2 : (wd == 2'b11) ? 4 : 0;
      er  = (n == 0) || (aa < BASE) || (aa + n > longint'(BASE) + DEPTH);
      mis = (n == 2 && aa % 2 != 0) || (n == 4 && aa % 4 != 0);
      rd  = 32'h0;
      lat = 1;
      wrc = 0;
      if (!er) begin
         lat = mis ? n : 1;
         if (w) begin
            wrc = mis ? n : 1;
            for (int i = 0; i < n; i++) ref_mem[10'(aa + i)] = d[8*i +: 8];
         end else begin
            for (int i = 0; i < n; i++) rd = rd | (32'(ref_mem[10'(aa + i)]) << (8 * i));
            if (sg && n == 1 && rd[7])  rd = rd | 32'hFFFF_FF00;
            if (sg && n == 2 && rd[15]) rd = rd | 32'hFFFF_0000;
         end
      end
   endtask

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Issues one request from an idle cycle and waits (bounded) for its response.
   task automatic do_req(input logic w, input logic [1:0] wd, input logic sg, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic er,
                         output int lat, output int wrc);
      req_valid  = 1'b1;
      req_write  = w;
      req_width  = wd;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = d;
      step();
      req_valid = 1'b0;
      lat = 0;
      wrc = 0;
      rd  = 32'hxxxx_xxxx;
      er  = 1'bx;
      for (int c = 1; c <= 8; c++) begin
         if (mem_rw === 1'b0) wrc++;
         step();
         if (rsp_valid === 1'b1) begin
            lat = c;
            rd  = rsp_rdata;
            er  = rsp_error;
            break;
         end
      end
      $display("txn w=%0d wd=%0d s=%0d a=%h d=%h -> rdata=%h err=%0d lat=%0d wr=%0d",
               w, wd, sg, a, d, rd, er, lat, wrc);
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  wd;
      logic        sg;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          wrc;
   } vec_t;

   vec_t tv [18];

   logic [31:0] g_rd, e_rd;
   logic        g_er, e_er;
   int          g_lat, e_lat, g_wr, e_wr;
   logic [7:0]  old33, old34;
   bit          saw_rsp;

   initial begin
      tv[0]  = '{1'b1, 2'b11, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 1, 1};
      tv[1]  = '{1'b0, 2'b11, 1'b0, BASE + 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, 0};
      tv[2]  = '{1'b1, 2'b11, 1'b0, BASE + 32'h05, 32'h1122_3344, 32'h0,         1'b0, 4, 4};
      tv[3]  = '{1'b0, 2'b11, 1'b0, BASE + 32'h05, 32'h0,         32'h1122_3344, 1'b0, 4, 0};
      tv[4]  = '{1'b0, 2'b01, 1'b0, BASE + 32'h08, 32'h0,         32'h0000_0011, 1'b0, 1, 0};
      tv[5]  = '{1'b1, 2'b10, 1'b0, BASE + 32'h21, 32'h0000_80F0, 32'h0,         1'b0, 2, 2};
      tv[6]  = '{1'b0, 2'b10, 1'b1, BASE + 32'h21, 32'h0,         32'hFFFF_80F0, 1'b0, 2, 0};
      tv[7]  = '{1'b0, 2'b10, 1'b0, BASE + 32'h21, 32'h0,         32'h0000_80F0, 1'b0, 2, 0};
      tv[8]  = '{1'b0, 2'b01, 1'b1, BASE + 32'h22, 32'h0,         32'hFFFF_FF80, 1'b0, 1, 0};
      tv[9]  = '{1'b0, 2'b11, 1'b0, 32'h00FF_FFFE, 32'h0,         32'h0,         1'b1, 1, 0};
      tv[10] = '{1'b1, 2'b11, 1'b0, TOP - 32'd2,   32'h5555_AAAA, 32'h0,         1'b1, 1, 0};
      tv[11] = '{1'b1, 2'b00, 1'b0, BASE + 32'h40, 32'h1234_5678, 32'h0,         1'b1, 1, 0};
      tv[12] = '{1'b1, 2'b11, 1'b0, TOP - 32'd4,   32'hCAFE_F00D, 32'h0,         1'b0, 1, 1};
      tv[13] = '{1'b0, 2'b11, 1'b0, TOP - 32'd4,   32'h0,         32'hCAFE_F00D, 1'b0, 1, 0};
      tv[14] = '{1'b0, 2'b01, 1'b1, TOP - 32'd1,   32'h0,         32'hFFFF_FFCA, 1'b0, 1, 0};
      tv[15] = '{1'b0, 2'b10, 1'b0, TOP - 32'd1,   32'h0,         32'h0,         1'b1, 1, 0};
      tv[16] = '{1'b0, 2'b10, 1'b0, TOP - 32'd2,   32'h0,         32'h0000_CAFE, 1'b0, 1, 0};
      tv[17] = '{1'b0, 2'b01, 1'b0, BASE - 32'd1,  32'h0,         32'h0,         1'b1, 1, 0};

      for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);

      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_width  = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      step();
      step();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_error", 32'(rsp_error), 32'd0);
      check("rst_mem_rw", 32'(mem_rw), 32'd1);
      check("rst_mem_width", 32'(mem_width), 32'd3);
      check("rst_mem_address", mem_address, BASE);
      check("rst_mem_data_in", mem_data_in, 32'h0);
      check("rst_mem_signed", 32'(mem_signed), 32'd0);
      reset_n = 1'b1;
      step();

      // Directed vector table
      for (int i = 0; i < 18; i++) begin
         do_req(tv[i].w, tv[i].wd, tv[i].sg, tv[i].a, tv[i].d, g_rd, g_er, g_lat, g_wr);
         ref_req(tv[i].w, tv[i].wd, tv[i].sg, tv[i].a, tv[i].d, e_rd, e_er, e_lat, e_wr);
         check($sformatf("tv%0d_rdata", i), g_rd, tv[i].rd);
         check($sformatf("tv%0d_error", i), 32'(g_er), 32'(tv[i].er));
         check($sformatf("tv%0d_latency", i), 32'(g_lat), 32'(tv[i].lat));
         check($sformatf("tv%0d_write_cycles", i), 32'(g_wr), 32'(tv[i].wrc));
      end

      // Request held during a split load is accepted only on the edge ending the response pulse
      ref_req(1'b0, 2'b11, 1'b0, BASE + 32'h05, 32'h0, e_rd, e_er, e_lat, e_wr);
      req_valid = 1'b1; req_write = 1'b0; req_width = 2'b11; req_signed = 1'b0;
      req_addr = BASE + 32'h05; req_wdata = 32'h0;
      step();
      req_addr = BASE + 32'h10;
      check("hold_ready_i0", 32'(req_ready), 32'd0);
      for (int c = 1; c <= 3; c++) begin
         step();
         check($sformatf("hold_ready_i%0d", c), 32'(req_ready), 32'd0);
         check($sformatf("hold_rsp_i%0d", c), 32'(rsp_valid), 32'd0);
      end
      step();
      check("hold_split_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_split_ready", 32'(req_ready), 32'd1);
      check("hold_split_rdata", rsp_rdata, e_rd);
      ref_req(1'b0, 2'b11, 1'b0, BASE + 32'h10, 32'h0, e_rd, e_er, e_lat, e_wr);
      step();
      req_valid = 1'b0;
      check("hold_pulse_single", 32'(rsp_valid), 32'd0);
      check("hold_second_busy", 32'(req_ready), 32'd0);
      step();
      check("hold_second_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_second_rdata", rsp_rdata, e_rd);

      // Back-to-back aligned loads with req_valid held high: one response every 2 cycles
      req_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_write = 1'b0; req_width = 2'b11; req_signed = 1'b0;
         req_addr = (k == 1) ? (TOP - 32'd4) : (BASE + 32'h10);
         ref_req(1'b0, 2'b11, 1'b0, req_addr, 32'h0, e_rd, e_er, e_lat, e_wr);
         check($sformatf("b2b%0d_ready", k), 32'(req_ready), 32'd1);
         step();
         check($sformatf("b2b%0d_busy_rsp", k), 32'(rsp_valid), 32'd0);
         step();
         check($sformatf("b2b%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
         check($sformatf("b2b%0d_rdata", k), rsp_rdata, e_rd);
      end
      req_valid = 1'b0;
      step();

      // Reset during byte 1 of a misaligned store: bytes 0 and 1 land, the rest do not
      old33 = ref_mem[10'h033];
      old34 = ref_mem[10'h034];
      req_valid = 1'b1; req_write = 1'b1; req_width = 2'b11; req_signed = 1'b0;
      req_addr = BASE + 32'h31; req_wdata = 32'hAABB_CCDD;
      step();
      req_valid = 1'b0;
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_rsp_rdata", rsp_rdata, 32'h0);
      check("abort_mem_rw", 32'(mem_rw), 32'd1);
      check("abort_mem_address", mem_address, BASE);
      saw_rsp = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
      end
      check("abort_no_rsp", 32'(saw_rsp), 32'd0);
      ref_mem[10'h031] = 8'hDD;
      ref_mem[10'h032] = 8'hCC;
      for (int b = 0; b < 4; b++) begin
         do_req(1'b0, 2'b01, 1'b0, BASE + 32'h31 + 32'(b), 32'h0, g_rd, g_er, g_lat, g_wr);
         e_rd = (b == 0) ? 32'hDD : (b == 1) ? 32'hCC : (b == 2) ? 32'(old33) : 32'(old34);
         check($sformatf("abort_byte%0d", b), g_rd, e_rd);
      end

      // Randomized requests against the reference model
      for (int t = 0; t < 300; t++) begin
         logic        w, sg;
         logic [1:0]  wd;
         logic [31:0] a, d;
         int          sel;
         w   = 1'($urandom_range(0, 1));
         sg  = 1'($urandom_range(0, 1));
         wd  = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         sel = $urandom_range(0, 9);
         if (sel < 8)       a = BASE + 32'($urandom_range(0, 32'h1F0));
         else if (sel == 8) a = TOP - 32'($urandom_range(1, 8));
         else               a = $urandom;
         d = $urandom;
         ref_req(w, wd, sg, a, d, e_rd, e_er, e_lat, e_wr);
         do_req(w, wd, sg, a, d, g_rd, g_er, g_lat, g_wr);
         check($sformatf("rnd%0d_rdata", t), g_rd, e_rd);
         check($sformatf("rnd%0d_error", t), 32'(g_er), 32'(e_er));
         check($sformatf("rnd%0d_latency", t), 32'(g_lat), 32'(e_lat));
         check($sformatf("rnd%0d_write_cycles", t), 32'(g_wr), 32'(e_wr));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
